// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the branch predictor scheduler.
package bp_pkg;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} bp_state_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [1:0] sat_update(input logic [1:0] counter, input logic taken);
    logic [1:0] r_next;
    case (counter)
      SNT:     r_next = taken ? WNT : SNT;
      WNT:     r_next = taken ? WT  : SNT;
      WT:      r_next = taken ? ST  : WNT;
      default: r_next = taken ? ST  : WT;
    endcase
    return r_next;
  endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Synchronous update queue holding {idx, taken}; flush empties it in one cycle.
module bp_update_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !full && !flush;
  assign w_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is data only; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == (PW+1)'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/branch_pred_scheduler.sv
// Shared 2-bit counter table with single-port arbitration between lookups and queued updates.
// Optional statistics outputs are enabled by defining BPS_STATS_EN.
module branch_pred_scheduler
  import bp_pkg::*;
#(
  parameter int IDX_W  = 4,
  parameter int QDEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             update_valid,
  input  logic [IDX_W-1:0] update_idx,
  input  logic             update_taken,
  input  logic             update_mispred,
  output logic             update_ready,
  output logic             init_done
`ifdef BPS_STATS_EN
  ,
  output logic [31:0]      stat_lookups,
  output logic [31:0]      stat_mispred
`endif
);
  localparam int NENT = 2**IDX_W;

  bp_state_e        r_state;
  bp_state_e        w_state_nxt;
  logic [IDX_W-1:0] r_sweep_ptr;
  logic [1:0]       r_table [NENT];

  logic             w_run;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_do_read;
  logic             w_do_write;
  logic             w_tbl_we;
  logic [IDX_W-1:0] w_wr_idx;
  logic [1:0]       w_wr_data;
  logic [IDX_W:0]   w_fifo_din;
  logic [IDX_W:0]   w_fifo_dout;
  logic [IDX_W-1:0] w_head_idx;

  logic             r_pred_valid;
  logic             r_pred_taken;
  logic [IDX_W-1:0] r_pred_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= INIT;
      r_sweep_ptr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_ptr <= (flush || r_state == RUN) ? '0 : r_sweep_ptr + IDX_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == INIT) begin
      if (!flush && r_sweep_ptr == IDX_W'(NENT-1)) w_state_nxt = RUN;
    end else begin
      if (flush) w_state_nxt = INIT;
    end
  end

  assign w_run      = (r_state == RUN);
  assign w_head_idx = w_fifo_dout[IDX_W:1];

  // A full queue wins the port so execute is never blocked for more than one cycle.
  always_comb begin
    w_do_read  = 1'b0;
    w_do_write = 1'b0;
    w_tbl_we   = 1'b0;
    w_wr_idx   = r_sweep_ptr;
    w_wr_data  = WNT;
    if (r_state == INIT) begin
      w_tbl_we = !flush;
    end else if (!flush) begin
      if (w_full)            w_do_write = 1'b1;
      else if (lookup_valid) w_do_read  = 1'b1;
      else if (!w_empty)     w_do_write = 1'b1;
      if (w_do_write) begin
        w_tbl_we  = 1'b1;
        w_wr_idx  = w_head_idx;
        w_wr_data = sat_update(r_table[w_head_idx], w_fifo_dout[0]);
      end
    end
  end

  assign lookup_ready = w_run && !w_full;
  assign update_ready = w_run && !w_full;
  assign init_done    = w_run;

  assign w_push     = update_valid && update_ready;
  assign w_fifo_din = {update_idx, update_taken};

  bp_update_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (IDX_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (w_push),
    .din   (w_fifo_din),
    .pop   (w_do_write),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (w_tbl_we) r_table[w_wr_idx] <= w_wr_data;
  end

  // Prediction stage: registered read of the table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_idx   <= '0;
    end else begin
      r_pred_valid <= w_do_read;
      if (w_do_read) begin
        r_pred_taken <= r_table[lookup_idx][1];
        r_pred_idx   <= lookup_idx;
      end
    end
  end

  assign pred_valid = r_pred_valid;
  assign pred_taken = r_pred_taken;
  assign pred_idx   = r_pred_idx;

`ifdef BPS_STATS_EN
  logic [31:0] r_stat_lookups;
  logic [31:0] r_stat_mispred;

  // Statistics survive flush; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_lookups <= '0;
      r_stat_mispred <= '0;
    end else begin
      if (w_do_read && r_stat_lookups != '1)
        r_stat_lookups <= r_stat_lookups + 32'd1;
      if (w_push && update_mispred && r_stat_mispred != '1)
        r_stat_mispred <= r_stat_mispred + 32'd1;
    end
  end

  assign stat_lookups = r_stat_lookups;
  assign stat_mispred = r_stat_mispred;
`else
  logic w_unused_mispred;
  assign w_unused_mispred = update_mispred;
`endif

endmodule

// File: tb/tb_branch_pred_scheduler.sv
// Directed self-checking bench for branch_pred_scheduler (IDX_W=4, QDEPTH=4).
module tb_branch_pred_scheduler;
  localparam int IDX_W  = 4;
  localparam int QDEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             lookup_valid = 1'b0;
  logic [IDX_W-1:0] lookup_idx = '0;
  logic             lookup_ready;
  logic             pred_valid;
  logic             pred_taken;
  logic [IDX_W-1:0] pred_idx;
  logic             update_valid = 1'b0;
  logic [IDX_W-1:0] update_idx = '0;
  logic             update_taken = 1'b0;
  logic             update_mispred = 1'b0;
  logic             update_ready;
  logic             init_done;
`ifdef BPS_STATS_EN
  logic [31:0]      stat_lookups;
  logic [31:0]      stat_mispred;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int lowcnt;

  always #5 clk = ~clk;

  branch_pred_scheduler #(
    .IDX_W  (IDX_W),
    .QDEPTH (QDEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .lookup_valid   (lookup_valid),
    .lookup_idx     (lookup_idx),
    .lookup_ready   (lookup_ready),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_idx       (pred_idx),
    .update_valid   (update_valid),
    .update_idx     (update_idx),
    .update_taken   (update_taken),
    .update_mispred (update_mispred),
    .update_ready   (update_ready),
    .init_done      (init_done)
`ifdef BPS_STATS_EN
    ,
    .stat_lookups   (stat_lookups),
    .stat_mispred   (stat_mispred)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic lookup(input string tag, input logic [IDX_W-1:0] idx, input logic exp_t);
    lookup_valid = 1'b1;
    lookup_idx   = idx;
    check({tag, "_rdy"}, 32'(lookup_ready), 32'd1);
    tick();
    lookup_valid = 1'b0;
    check({tag, "_pv"},  32'(pred_valid), 32'd1);
    check({tag, "_pt"},  32'(pred_taken), 32'(exp_t));
    check({tag, "_pi"},  32'(pred_idx),   32'(idx));
  endtask

  task automatic update(input string tag, input logic [IDX_W-1:0] idx, input logic tk,
                        input logic mp);
    update_valid   = 1'b1;
    update_idx     = idx;
    update_taken   = tk;
    update_mispred = mp;
    check({tag, "_urdy"}, 32'(update_ready), 32'd1);
    tick();
    update_valid   = 1'b0;
    update_mispred = 1'b0;
  endtask

  // Counts INIT cycles in which the block must refuse all traffic and stay silent.
  task automatic count_init(input string tag);
    lowcnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (!lookup_ready && !update_ready && !init_done && !pred_valid) lowcnt++;
      tick();
    end
    check({tag, "_init_cycles"}, 32'(lowcnt), 32'd16);
    check({tag, "_init_done"},   32'(init_done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    lookup_valid = 1'b1;
    lookup_idx   = 4'd3;
    #1;
    check("rst_lk_rdy", 32'(lookup_ready), 32'd0);
    check("rst_up_rdy", 32'(update_ready), 32'd0);
    check("rst_pv",     32'(pred_valid),   32'd0);
    check("rst_pt",     32'(pred_taken),   32'd0);
    check("rst_pi",     32'(pred_idx),     32'd0);
    check("rst_done",   32'(init_done),    32'd0);
    idle(2);
    rst_n = 1'b1;

    // Lookup held high through INIT; accepted on the first RUN cycle.
    count_init("boot");
    check("boot_lk_rdy", 32'(lookup_ready), 32'd1);
    tick();
    lookup_valid = 1'b0;
    check("boot_pv", 32'(pred_valid), 32'd1);
    check("boot_pt", 32'(pred_taken), 32'd0);
    check("boot_pi", 32'(pred_idx),   32'd3);
    tick();
    check("boot_pv_pulse", 32'(pred_valid), 32'd0);

    // idx 5: 01 -> 10 -> 11 -> 11, then down 11 -> 10 -> 01.
    for (int i = 0; i < 3; i++) update("u5t", 4'd5, 1'b1, 1'b0);
    idle(3);
    lookup("lk5_sat", 4'd5, 1'b1);
    update("u5n", 4'd5, 1'b0, 1'b0);
    idle(2);
    lookup("lk5_10", 4'd5, 1'b1);
    update("u5n", 4'd5, 1'b0, 1'b0);
    idle(2);
    lookup("lk5_01", 4'd5, 1'b0);

    // idx 2: saturate at 00, then climb 00 -> 01 -> 10.
    for (int i = 0; i < 3; i++) update("u2n", 4'd2, 1'b0, 1'b0);
    idle(3);
    lookup("lk2_00", 4'd2, 1'b0);
    update("u2t", 4'd2, 1'b1, 1'b0);
    update("u2t", 4'd2, 1'b1, 1'b0);
    idle(3);
    lookup("lk2_10", 4'd2, 1'b1);

    // Starvation: continuous lookups fill the queue, then one forced write.
    lookup_valid = 1'b1;
    lookup_idx   = 4'd7;
    update_valid = 1'b1;
    update_idx   = 4'd9;
    update_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("stv_urdy", 32'(update_ready), 32'd1);
      check("stv_lrdy", 32'(lookup_ready), 32'd1);
      tick();
    end
    check("stv_full_urdy", 32'(update_ready), 32'd0);
    check("stv_full_lrdy", 32'(lookup_ready), 32'd0);
    check("stv_full_pv",   32'(pred_valid),   32'd1);
    tick();
    check("stv_after_urdy", 32'(update_ready), 32'd1);
    check("stv_after_lrdy", 32'(lookup_ready), 32'd1);
    check("stv_after_pv",   32'(pred_valid),   32'd0);
    tick();
    update_valid = 1'b0;
    lookup_valid = 1'b0;
    check("stv_last_pv", 32'(pred_valid), 32'd1);
    check("stv_last_pi", 32'(pred_idx),   32'd7);
    idle(6);
    lookup("lk9", 4'd9, 1'b1);
    lookup("lk7", 4'd7, 1'b0);

    // Flush with three queued updates to idx 11 and a lookup in flight.
    lookup_valid = 1'b1;
    lookup_idx   = 4'd0;
    for (int i = 0; i < 3; i++) begin
      update_valid = 1'b1;
      update_idx   = 4'd11;
      update_taken = 1'b1;
      check("fl_urdy", 32'(update_ready), 32'd1);
      tick();
    end
    update_valid = 1'b0;
    flush = 1'b1;
    check("fl_lrdy", 32'(lookup_ready), 32'd1);
    tick();
    flush = 1'b0;
    lookup_valid = 1'b0;
    check("fl_pv",   32'(pred_valid), 32'd0);
    count_init("flush");
    idle(6);
    lookup("fl_lk11", 4'd11, 1'b0);
    lookup("fl_lk9",  4'd9,  1'b0);
    lookup("fl_lk2",  4'd2,  1'b0);

    // Fresh reset, then statistics accumulate and survive a flush.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst2_done", 32'(init_done),  32'd0);
    check("rst2_pi",   32'(pred_idx),   32'd0);
`ifdef BPS_STATS_EN
    check("rst2_stl", stat_lookups, 32'd0);
    check("rst2_stm", stat_mispred, 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    count_init("rst2");
    for (int i = 0; i < 10; i++) lookup("st_lk", 4'(i), 1'b0);
    update("st_u", 4'd1, 1'b1, 1'b1);
    update("st_u", 4'd1, 1'b1, 1'b1);
    update("st_u", 4'd1, 1'b0, 1'b0);
    update("st_u", 4'd1, 1'b1, 1'b1);
    idle(3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle(2);
    check("st_flush_done", 32'(init_done), 32'd0);
`ifdef BPS_STATS_EN
    check("st_lookups", stat_lookups, 32'd10);
    check("st_mispred", stat_mispred, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_pred_scheduler.md
# branch_pred_scheduler

- Owns a shared table of 2-bit saturating branch counters and schedules all access to it.
- Table is single-ported, one operation per cycle.
- Two requesters compete for that port:
  - fetch-side lookups, which need a prediction;
  - execute-side resolutions, which update a counter and are buffered in a small queue.
- Sits between fetch and execute; replaces per-branch standalone predictor instances with one arbitrated resource.

## Interface
Parameters:
- IDX_W, 4, table index width; table holds 2**IDX_W counters.
- QDEPTH, 4, update queue depth; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous request to clear the table and discard queued updates.
- lookup_valid  input  1  fetch requests a prediction.
- lookup_idx  input  IDX_W  table index of the lookup.
- lookup_ready  output  1  lookup is accepted when valid && ready.
- pred_valid  output  1  one-cycle pulse; prediction is on pred_taken/pred_idx.
- pred_taken  output  1  predicted direction, equal to counter[1].
- pred_idx  output  IDX_W  index the prediction belongs to.
- update_valid  input  1  execute resolves a branch.
- update_idx  input  IDX_W  index to update.
- update_taken  input  1  actual outcome.
- update_mispred  input  1  the resolved branch was mispredicted; used by statistics only.
- update_ready  output  1  update is accepted when valid && ready.
- init_done  output  1  high once the table is cleared and the block is in RUN.

## Operation
- FSM states are INIT and RUN.
- rst_n low or flush in RUN causes entry to INIT, with sweep pointer 0 and queue emptied.
- INIT:
  - writes 2'b01 (weakly not-taken) to entry sweep_ptr each cycle and increments the pointer;
  - after entry 2**IDX_W-1 is written, next state is RUN;
  - lookup_ready=0, update_ready=0, init_done=0;
  - flush during INIT restarts the sweep at 0.
- RUN port arbitration, evaluated each cycle in priority order:
  1. Queue full: write the queue head; lookup_ready=0.
  2. lookup_valid: read lookup_idx; lookup_ready=1.
  3. Queue non-empty: write the queue head.
  4. Otherwise the port is idle.
- lookup_ready = RUN && !full. It does not depend on lookup_valid.
- update_ready = RUN && !full.
  - Enqueue and dequeue in the same cycle are legal; count is unchanged.
  - An update enqueued in cycle t is written at cycle t+1 at the earliest.
- Counter write: taken gives min(c+1,3); not-taken gives max(c-1,0).
- Lookups read the table only. Queued updates to the same index are not forwarded, so stale predictions are acceptable by design.
- Queued updates to the same index are applied in order; each one reads the counter written by the previous one.
- flush in RUN:
  - discards queue contents;
  - suppresses any lookup or write that would occur that cycle;
  - pred_valid is 0 the following cycle.

## Timing
- Reset values:
  - lookup_ready=0, update_ready=0, pred_valid=0, pred_taken=0, pred_idx=0, init_done=0;
  - all statistics counters are 0.
- INIT lasts exactly 2**IDX_W cycles after rst_n deasserts or after flush.
  - With IDX_W=4: init_done rises on the 16th rising edge after release.
- Lookup accepted at edge t gives pred_valid=1 during cycle t+1 only. Outputs are registered.
- Back-to-back lookups give back-to-back predictions, at one per cycle.
- Sustained lookups starve queue writes until the queue is full. Then exactly one write proceeds and lookup_ready drops for that cycle.
- Queue pointers wrap modulo QDEPTH.
- Full/empty use a count register of width log2(QDEPTH)+1.

## Configuration
- BPS_STATS_EN, when defined:
  - adds outputs stat_lookups[31:0] and stat_mispred[31:0];
  - stat_lookups increments on each accepted lookup;
  - stat_mispred increments on each accepted update with update_mispred=1;
  - both saturate at all-ones;
  - both are cleared by rst_n only, not by flush.
- BPS_STATS_EN undefined: the ports and counters are absent and update_mispred is ignored.

## Structure
- Shared package bp_pkg holds:
  - the state enum {INIT, RUN};
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - function sat_update(counter, taken).
- One sub-module, bp_update_fifo: QDEPTH x (IDX_W+1) synchronous FIFO with full, empty and a flush port.
- Table storage and the arbitration logic stay in the top module.

## Test plan
- Release rst_n with lookup_valid held at 1 → lookup_ready=0 for 16 cycles; init_done rises at cycle 16; first prediction has pred_taken=0.
- Three updates idx 5 taken, then idle 3 cycles, then lookup idx 5 → counter goes 01→10→11→11; pred_taken=1 one cycle after acceptance.
- Continuous lookups while 5 updates are offered with QDEPTH=4 → update_ready drops after 4 updates; lookup_ready is low for exactly one cycle, then the 5th update is accepted.
- Update idx 2 not-taken three times, then lookup idx 2 → counter saturates at 00; pred_taken=0.
- Queue holds 3 updates, then flush → queue empties; init_done=0 for 16 cycles; a lookup of any updated index predicts 0.
- With BPS_STATS_EN: 10 lookups and 4 updates of which 3 have mispred=1, then flush → stat_lookups=10 and stat_mispred=3, unchanged by the flush.
